// File: rtl/asi_rw_arb.sv
// Purpose: arbitrates the ASI read and write user paths onto the single user memory port.
// Latency: grant is high one cycle after a request is seen in IDLE; it is decoded from registered state.
// Backpressure: ownership is held from grant until the owning side's busy falls; the loser waits.
module asi_rw_arb #(
    parameter int SLV_ARB = 0,
    parameter int SLV_STV = 4,
    parameter int STV_W   = $clog2(SLV_STV + 1)
) (
    input  logic       usr_clk,
    input  logic       usr_reset,
    input  logic       m_arff_rvalid,
    input  logic       m_rbusy,
    input  logic       m_awff_rvalid,
    input  logic       m_wbusy,
    output logic       rgranted,
    output logic       wgranted,
    output logic [2:0] arb_state,
    output logic       error_arb
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        R_GNT = 3'd1,
        R_BSY = 3'd2,
        W_GNT = 3'd3,
        W_BSY = 3'd4
    } state_t;

    localparam logic [STV_W-1:0] STV_MAX = STV_W'(SLV_STV);
    localparam logic [STV_W-1:0] STV_ONE = STV_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [STV_W-1:0] rd_stv;
    logic [STV_W-1:0] wr_stv;
    logic             rd_win;
    logic             state_ill;
    logic             rd_own;
    logic             wr_own;
    logic             busy_err;
    logic             enter_r;
    logic             enter_w;

    // Tie-break: a starved side overrides the fixed preference.
    always_comb begin
        rd_win = (SLV_ARB != 0);
        if (rd_stv == STV_MAX) begin
            rd_win = 1'b1;
        end else if (wr_stv == STV_MAX) begin
            rd_win = 1'b0;
        end
    end

    // Next-state decode; unreachable encodings fall back to IDLE and are flagged.
    always_comb begin
        state_nxt = state;
        state_ill = 1'b0;
        case (state)
            IDLE: begin
                if (m_arff_rvalid && m_awff_rvalid) begin
                    state_nxt = rd_win ? R_GNT : W_GNT;
                end else if (m_arff_rvalid) begin
                    state_nxt = R_GNT;
                end else if (m_awff_rvalid) begin
                    state_nxt = W_GNT;
                end
            end
            R_GNT: begin
                if (m_rbusy) begin
                    state_nxt = R_BSY;
                end else if (!m_arff_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            R_BSY: begin
                if (!m_rbusy) begin
                    state_nxt = IDLE;
                end
            end
            W_GNT: begin
                if (m_wbusy) begin
                    state_nxt = W_BSY;
                end else if (!m_awff_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            W_BSY: begin
                if (!m_wbusy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                state_ill = 1'b1;
            end
        endcase
    end

    // Busy from a side that does not own the port, or from both sides, is a protocol violation.
    always_comb begin
        rd_own   = (state == R_GNT) || (state == R_BSY);
        wr_own   = (state == W_GNT) || (state == W_BSY);
        busy_err = (m_rbusy && !rd_own) || (m_wbusy && !wr_own) ||
                   (m_rbusy && m_wbusy) || state_ill;
        enter_r  = (state == IDLE) && (state_nxt == R_GNT);
        enter_w  = (state == IDLE) && (state_nxt == W_GNT);
    end

    // State, starvation counters and sticky error flag.
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            state     <= IDLE;
            rd_stv    <= '0;
            wr_stv    <= '0;
            error_arb <= 1'b0;
        end else begin
            state <= state_nxt;
            if (enter_r) begin
                rd_stv <= '0;
            end else if (enter_w && m_arff_rvalid && (rd_stv != STV_MAX)) begin
                rd_stv <= rd_stv + STV_ONE;
            end
            if (enter_w) begin
                wr_stv <= '0;
            end else if (enter_r && m_awff_rvalid && (wr_stv != STV_MAX)) begin
                wr_stv <= wr_stv + STV_ONE;
            end
            if (busy_err) begin
                error_arb <= 1'b1;
            end
        end
    end

    assign rgranted  = (state == R_GNT);
    assign wgranted  = (state == W_GNT);
    assign arb_state = state;

endmodule

// File: doc/asi_rw_arb.md
Name: asi_rw_arb

Overview:
- Arbiter between the ASI read and write user-side paths for the single user memory port.
- Sits in the usr_clk domain. It takes request and busy indications from the read and write interfaces, issues one-hot grants, and holds ownership of the port for a whole burst.
- Fixed priority is set by SLV_ARB. A bounded anti-starvation override guarantees the losing side is served.

Parameters:
- SLV_ARB, 0: 1 = read has priority on a tie; 0 = write has priority on a tie.
- SLV_STV, 4: number of consecutive lost arbitrations after which the waiting side is forced to win. Legal range 1..255.
- STV_W, $clog2(SLV_STV+1): starvation counter width (derived).

Ports:
- usr_clk input 1: user clock; all logic on its rising edge.
- usr_reset input 1: synchronous, active-high reset.
- m_arff_rvalid input 1: read request pending (AR buffer non-empty and read path idle).
- m_rbusy input 1: read path issuing a beat this cycle (m_re).
- m_awff_rvalid input 1: write request pending.
- m_wbusy input 1: write path issuing a beat this cycle.
- rgranted output 1: read path may pop its AR buffer this cycle.
- wgranted output 1: write path may pop its AW buffer this cycle.
- arb_state output 3: current state encoding, for debug.
- error_arb output 1: sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock, usr_clk. usr_reset is synchronous and active-high.
- Reset values: state = IDLE; rgranted = 0; wgranted = 0; both starvation counters = 0; error_arb = 0. Reset asserted mid-burst returns to IDLE on the next edge, whatever the busy inputs are doing.
- States: IDLE, R_GNT, R_BSY, W_GNT, W_BSY.
- Grant outputs are decoded from the registered state only, with no input-to-output combinational path: rgranted = (state == R_GNT); wgranted = (state == W_GNT). They are never high together.
- IDLE transitions:
  - Only m_arff_rvalid -> R_GNT.
  - Only m_awff_rvalid -> W_GNT.
  - Both -> winner goes to its GNT state.
  - Neither -> stay in IDLE.
- Winner on a tie:
  - Read wins if rd_stv == SLV_STV.
  - Otherwise write wins if wr_stv == SLV_STV.
  - Otherwise the SLV_ARB preference wins.
  - Both counters cannot be saturated at once.
- Latency: the grant is high one cycle after the request is first seen in IDLE.
- R_GNT transitions:
  - m_rbusy = 1 (the pop happens this cycle) -> R_BSY.
  - m_arff_rvalid = 0 and m_rbusy = 0 (request withdrawn) -> IDLE.
  - Otherwise stay in R_GNT.
- R_BSY transitions: m_rbusy = 0 -> IDLE; otherwise stay. The grant is low in R_BSY, so a second pop is impossible.
- The W_GNT / W_BSY pair mirrors the read pair using m_wbusy and m_awff_rvalid.
- Turnaround cost:
  - A single-beat burst takes 3 cycles: GNT, BSY, IDLE. It leaves R_BSY at its first cycle because m_rbusy is already 0.
  - Back-to-back bursts of one side cost one idle cycle between them.
- Starvation counters:
  - On entering W_GNT while m_arff_rvalid = 1: rd_stv increments, saturating at SLV_STV.
  - On entering R_GNT: rd_stv clears to 0.
  - wr_stv is symmetric.
  - A counter is not cleared when its side's request drops; it clears only on that side's grant.
- error_arb is set and held until reset on any of:
  - m_rbusy = 1 in a state other than R_GNT or R_BSY.
  - m_wbusy = 1 in a state other than W_GNT or W_BSY.
  - m_rbusy and m_wbusy both high.
- arb_state encoding: IDLE = 0, R_GNT = 1, R_BSY = 2, W_GNT = 3, W_BSY = 4.
- Values 5..7 are illegal. If reached, the next state is IDLE and error_arb is set.

Test Plan:
- Reset, then a single read request: pulse usr_reset 2 cycles; m_arff_rvalid = 1 at cycle 0 -> rgranted = 1 at cycle 1. m_rbusy = 1 at cycle 1 -> rgranted = 0 at cycle 2, state R_BSY. m_rbusy = 0 at cycle 2 -> IDLE at cycle 3. All outputs 0 during reset.
- Tie with priority: SLV_ARB = 0, both requests high in IDLE -> wgranted first. SLV_ARB = 1 -> rgranted first. The grants are never simultaneous.
- Long burst hold: write granted, m_wbusy high for 16 cycles while m_arff_rvalid = 1 -> rgranted stays 0 throughout. rgranted = 1 exactly 2 cycles after m_wbusy falls (one cycle to return to IDLE, one to enter R_GNT).
- Starvation: SLV_ARB = 0, SLV_STV = 4, both requests held high, each burst 1 beat -> sequence W, W, W, W, R. rd_stv reads 4 before the read grant and 0 after it.
- Withdrawal: m_arff_rvalid drops in R_GNT with m_rbusy = 0 -> IDLE next cycle. No error is flagged and no busy phase occurs.
- Protocol error and reset mid-operation: m_rbusy = 1 while in IDLE -> error_arb = 1 next cycle and held. usr_reset asserted in W_BSY with m_wbusy = 1 -> IDLE and error_arb = 0 after the edge.
